// File: rtl/cp0_cause_epc_if.sv
// Pipeline <-> CP0 cause/EPC unit signal bundle.
// master = pipeline/status side, slave = cp0_cause_epc.
interface cp0_cause_epc_if #(
  parameter int NUM_HW_IRQ = 6,
  parameter int NUM_SW_IRQ = 2,
  parameter int EXC_W      = 5,
  parameter int ADDR_W     = 32
);
  logic [NUM_HW_IRQ-1:0]                      hw_irq;
  logic                                       sw_we;
  logic [NUM_SW_IRQ-1:0]                      sw_wdata;
  logic [NUM_HW_IRQ+NUM_SW_IRQ-1:0]           im;
  logic                                       ie;
  logic                                       exc_valid;
  logic [EXC_W-1:0]                           exc_code;
  logic [ADDR_W-1:0]                          exc_pc;
  logic                                       exc_bd;
  logic                                       eret;
  logic                                       take_exc;
  logic                                       exl;
  logic                                       irq_pending;
  logic                                       exc_lost;
  logic [ADDR_W-1:0]                          epc_out;
  logic [NUM_HW_IRQ+NUM_SW_IRQ+EXC_W:0]       cause_out;

  modport master (
    output hw_irq, sw_we, sw_wdata, im, ie, exc_valid, exc_code, exc_pc, exc_bd, eret,
    input  take_exc, exl, irq_pending, exc_lost, epc_out, cause_out
  );

  modport slave (
    input  hw_irq, sw_we, sw_wdata, im, ie, exc_valid, exc_code, exc_pc, exc_bd, eret,
    output take_exc, exl, irq_pending, exc_lost, epc_out, cause_out
  );
endinterface

// File: rtl/cp0_cause_epc.sv
// CP0 Cause/EPC unit: exception/interrupt arbitration and EXL sequencing.
// Optional macro CP0_IRQ_SYNC_EN adds a two-flop synchroniser on hw_irq.
module cp0_cause_epc #(
  parameter int NUM_HW_IRQ = 6,
  parameter int NUM_SW_IRQ = 2,
  parameter int EXC_W      = 5,
  parameter int ADDR_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  cp0_cause_epc_if.slave   bus
);
  localparam int IRQ_W = NUM_HW_IRQ + NUM_SW_IRQ;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_HANDLER} state_t;

  state_t                  state_reg, state_next;
  logic [NUM_HW_IRQ-1:0]   ip_hw_reg;
  logic [NUM_HW_IRQ-1:0]   hw_in;
  logic [NUM_SW_IRQ-1:0]   ip_sw_reg;
  logic                    bd_reg;
  logic [EXC_W-1:0]        code_reg;
  logic [ADDR_W-1:0]       epc_reg;
  logic                    lost_reg;
  logic [IRQ_W-1:0]        ip_all;
  logic [IRQ_W-1:0]        ip_masked;
  logic                    irq_pend;
  logic                    enter;
  logic                    take_exc_next;
  logic                    exl_next;

`ifdef CP0_IRQ_SYNC_EN
  logic [NUM_HW_IRQ-1:0]   sync1_reg, sync2_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= bus.hw_irq;
      sync2_reg <= sync1_reg;
    end
  end

  assign hw_in = sync2_reg;
`else
  assign hw_in = bus.hw_irq;
`endif

  // IP_hw is a level copy of the lines, not a latch of edges.
  always_ff @(posedge clk) begin
    if (!rst_n) ip_hw_reg <= '0;
    else        ip_hw_reg <= hw_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         ip_sw_reg <= '0;
    else if (bus.sw_we) ip_sw_reg <= bus.sw_wdata;
  end

  assign ip_all = {ip_hw_reg, ip_sw_reg};

  generate
    for (genvar gi = 0; gi < IRQ_W; gi++) begin : g_mask
      assign ip_masked[gi] = ip_all[gi] & bus.im[gi];
    end
  endgenerate

  assign irq_pend = bus.ie & (|ip_masked);

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    enter         = 1'b0;
    take_exc_next = 1'b0;
    exl_next      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.exc_valid | irq_pend) begin
          state_next = S_FLUSH;
          enter      = 1'b1;
        end
      end
      S_FLUSH: begin
        take_exc_next = 1'b1;
        exl_next      = 1'b1;
        state_next    = S_HANDLER;
      end
      S_HANDLER: begin
        exl_next = 1'b1;
        if (bus.eret) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Cause/EPC are captured only on entry and survive ERET for post-mortem reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bd_reg   <= 1'b0;
      code_reg <= '0;
      epc_reg  <= '0;
    end else if (enter) begin
      bd_reg   <= bus.exc_bd;
      code_reg <= bus.exc_valid ? bus.exc_code : '0;
      epc_reg  <= bus.exc_bd ? (bus.exc_pc - ADDR_W'(4)) : bus.exc_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                                       lost_reg <= 1'b0;
    else if (bus.exc_valid && (state_reg != S_IDLE))  lost_reg <= 1'b1;
  end

  assign bus.take_exc    = take_exc_next;
  assign bus.exl         = exl_next;
  assign bus.irq_pending = irq_pend;
  assign bus.exc_lost    = lost_reg;
  assign bus.epc_out     = epc_reg;
  assign bus.cause_out   = {bd_reg, ip_hw_reg, ip_sw_reg, code_reg};
endmodule

// File: tb/tb_cp0_cause_epc.sv
// Directed bench for cp0_cause_epc: per-cycle compare against a behavioural
// model plus literal expectations at key points of each scenario.
module tb_cp0_cause_epc;
  localparam int NHW = 6;
  localparam int NSW = 2;
  localparam int EW  = 5;
  localparam int AW  = 32;
`ifdef CP0_IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cp0_cause_epc_if #(.NUM_HW_IRQ(NHW), .NUM_SW_IRQ(NSW), .EXC_W(EW), .ADDR_W(AW)) bus ();

  cp0_cause_epc #(.NUM_HW_IRQ(NHW), .NUM_SW_IRQ(NSW), .EXC_W(EW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: "in flush", "in handler", latched fields, hw_irq history.
  logic            m_flush = 1'b0, m_handler = 1'b0;
  logic            m_bd = 1'b0, m_lost = 1'b0;
  logic [EW-1:0]   m_code = '0;
  logic [AW-1:0]   m_epc = '0;
  logic [NSW-1:0]  m_ip_sw = '0;
  logic [NHW-1:0]  m_hist [0:2] = '{default: '0};
  logic [NHW-1:0]  m_ip_hw;
  logic            m_idle, m_pend;

  assign m_ip_hw = m_hist[LAT-1];
  assign m_idle  = !m_flush && !m_handler;
  assign m_pend  = bus.ie && (|({m_ip_hw, m_ip_sw} & bus.im));

  always @(posedge clk) begin
    if (!rst_n) begin
      m_flush <= 1'b0; m_handler <= 1'b0; m_bd <= 1'b0; m_lost <= 1'b0;
      m_code <= '0; m_epc <= '0; m_ip_sw <= '0;
      m_hist[0] <= '0; m_hist[1] <= '0; m_hist[2] <= '0;
    end else begin
      if (m_idle && (bus.exc_valid || m_pend)) begin
        m_flush <= 1'b1;
        m_code  <= bus.exc_valid ? bus.exc_code : '0;
        m_bd    <= bus.exc_bd;
        m_epc   <= bus.exc_pc - (bus.exc_bd ? 32'd4 : 32'd0);
      end
      if (m_flush) begin
        m_flush   <= 1'b0;
        m_handler <= 1'b1;
      end
      if (m_handler && bus.eret) m_handler <= 1'b0;
      if (bus.exc_valid && !m_idle) m_lost <= 1'b1;
      if (bus.sw_we) m_ip_sw <= bus.sw_wdata;
      m_hist[0] <= bus.hw_irq;
      m_hist[1] <= m_hist[0];
      m_hist[2] <= m_hist[1];
    end
  end

  always @(negedge clk) begin
    chk("take_exc", 64'(bus.take_exc), 64'(m_flush));
    chk("exl", 64'(bus.exl), 64'(m_flush | m_handler));
    chk("irq_pending", 64'(bus.irq_pending), 64'(m_pend));
    chk("exc_lost", 64'(bus.exc_lost), 64'(m_lost));
    chk("epc_out", 64'(bus.epc_out), 64'(m_epc));
    chk("cause_out", 64'(bus.cause_out), 64'({m_bd, m_ip_hw, m_ip_sw, m_code}));
    if (bus.take_exc) pulses++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic enter_exc(input logic [EW-1:0] code, input logic [AW-1:0] pc, input logic bd);
    bus.exc_valid = 1'b1; bus.exc_code = code; bus.exc_pc = pc; bus.exc_bd = bd;
    tick();
    bus.exc_valid = 1'b0;
  endtask

  int p0;

  initial begin
    bus.hw_irq = 6'h3F; bus.sw_we = 1'b0; bus.sw_wdata = '0; bus.im = '0; bus.ie = 1'b0;
    bus.exc_valid = 1'b0; bus.exc_code = '0; bus.exc_pc = '0; bus.exc_bd = 1'b0; bus.eret = 1'b0;

    // Reset with all hw lines high
    tick(2);
    $display("txn reset: cause=0x%0h exl=%0b", bus.cause_out, bus.exl);
    chk("rst_cause", 64'(bus.cause_out), 64'd0);
    chk("rst_exl", 64'(bus.exl), 64'd0);
    chk("rst_epc", 64'(bus.epc_out), 64'd0);
    rst_n = 1'b1;
    tick(LAT);
    $display("txn release: cause=0x%0h", bus.cause_out);
    chk("ip_hw_after_release", 64'(bus.cause_out), 64'h1F80);
    bus.hw_irq = '0;
    tick(LAT);

    // Synchronous exception entry and return
    enter_exc(5'd12, 32'h0040_0010, 1'b0);
    $display("txn exc: take=%0b code=%0d epc=0x%0h", bus.take_exc, bus.cause_out[4:0], bus.epc_out);
    chk("entry_take", 64'(bus.take_exc), 64'd1);
    chk("entry_code", 64'(bus.cause_out[4:0]), 64'd12);
    chk("entry_epc", 64'(bus.epc_out), 64'h0040_0010);
    tick();
    chk("flush_one_cycle", 64'(bus.take_exc), 64'd0);
    chk("handler_exl", 64'(bus.exl), 64'd1);
    tick(2);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    $display("txn eret: exl=%0b epc=0x%0h", bus.exl, bus.epc_out);
    chk("eret_exl", 64'(bus.exl), 64'd0);
    chk("epc_retained", 64'(bus.epc_out), 64'h0040_0010);

    // ERET while idle is a no-op
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    $display("txn idle_eret: exl=%0b", bus.exl);
    chk("idle_eret_exl", 64'(bus.exl), 64'd0);

    // Delay-slot EPC wraps below zero
    enter_exc(5'd3, 32'h0, 1'b1);
    $display("txn bd_wrap: epc=0x%0h bd=%0b", bus.epc_out, bus.cause_out[13]);
    chk("bd_wrap_epc", 64'(bus.epc_out), 64'hFFFF_FFFC);
    chk("bd_flag", 64'(bus.cause_out[13]), 64'd1);
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;

    // Interrupt masking: hw line 2 maps to im[NSW+2]
    bus.ie = 1'b1; bus.im = '0; bus.hw_irq = 6'h04;
    tick(LAT + 1);
    chk("masked_pending", 64'(bus.irq_pending), 64'd0);
    chk("masked_no_take", 64'(bus.exl), 64'd0);
    bus.ie = 1'b0; bus.im = 8'h10;
    tick();
    chk("ie_off_pending", 64'(bus.irq_pending), 64'd0);
    chk("ie_off_exl", 64'(bus.exl), 64'd0);
    bus.ie = 1'b1;
    #1;
    chk("unmasked_pending", 64'(bus.irq_pending), 64'd1);
    tick();
    $display("txn irq: take=%0b code=%0d", bus.take_exc, bus.cause_out[4:0]);
    chk("irq_take", 64'(bus.take_exc), 64'd1);
    chk("irq_code", 64'(bus.cause_out[4:0]), 64'd0);
    tick(3);
    chk("no_irq_under_exl", 64'(bus.take_exc), 64'd0);
    bus.eret = 1'b1; bus.ie = 1'b0; bus.hw_irq = '0;
    tick();
    bus.eret = 1'b0;
    tick(LAT);

    // Exception beats simultaneous interrupt
    bus.hw_irq = 6'h04;
    tick(LAT);
    p0 = pulses;
    bus.ie = 1'b1;
    enter_exc(5'd4, 32'h0000_1000, 1'b0);
    bus.ie = 1'b0; bus.hw_irq = '0;
    $display("txn priority: code=%0d", bus.cause_out[4:0]);
    chk("prio_code", 64'(bus.cause_out[4:0]), 64'd4);
    tick(3);
    chk("prio_one_pulse", 64'(pulses - p0), 64'd1);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    tick(LAT);

    // Collision in HANDLER: eret wins, request lost, sw IP written
    enter_exc(5'd8, 32'h0000_2000, 1'b0);
    tick();
    p0 = pulses;
    bus.exc_valid = 1'b1; bus.exc_code = 5'd9; bus.eret = 1'b1;
    bus.sw_we = 1'b1; bus.sw_wdata = 2'b10;
    tick();
    bus.exc_valid = 1'b0; bus.eret = 1'b0; bus.sw_we = 1'b0;
    $display("txn collision: exl=%0b lost=%0b ip_sw=%0b", bus.exl, bus.exc_lost, bus.cause_out[6:5]);
    chk("coll_exl", 64'(bus.exl), 64'd0);
    chk("coll_lost", 64'(bus.exc_lost), 64'd1);
    chk("coll_ip_sw", 64'(bus.cause_out[6:5]), 64'd2);
    chk("coll_code_kept", 64'(bus.cause_out[4:0]), 64'd8);
    tick(2);
    chk("coll_no_second_take", 64'(pulses - p0), 64'd0);
    chk("lost_sticky", 64'(bus.exc_lost), 64'd1);

    // Reset during FLUSH
    enter_exc(5'd2, 32'h0000_3000, 1'b0);
    rst_n = 1'b0;
    tick();
    $display("txn reset_in_flush: take=%0b exl=%0b lost=%0b", bus.take_exc, bus.exl, bus.exc_lost);
    chk("rst_flush_take", 64'(bus.take_exc), 64'd0);
    chk("rst_flush_exl", 64'(bus.exl), 64'd0);
    chk("rst_flush_lost", 64'(bus.exc_lost), 64'd0);
    rst_n = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
